uart_receiver: RTL

//   Serial-to-parallel UART receiver; downstream consumer of uart_transmitter's o_tx line.

---
 rtl/uart_receiver.sv | 128 ++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle valid / frame-error pulses.
module uart_receiver #(
  parameter int CYCLES_PER_SAMPLE = 10416,
  parameter int HALF_SAMPLE       = CYCLES_PER_SAMPLE / 2
) (
  input  logic       clk,
  input  logic       i_reset,
  input  logic       i_rx,
  output logic [0:7] o_data,
  output logic       o_valid,
  output logic       o_frame_error,
  output logic       o_busy
);

  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge on rx_s
  // START     | confirming the start bit at its mid-point
  // DATA      | sampling 8 data bits at mid-bit
  // STOP      | sampling the stop bit at mid-bit
  // WAIT_HIGH | bad stop bit seen, waiting for the line to return high
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  localparam logic [15:0] HALF_LAST = 16'(HALF_SAMPLE - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CYCLES_PER_SAMPLE - 1);

  state_t      state;
  logic [15:0] cnt;
  logic [3:0]  bit_idx;
  logic [0:7]  shift;
  logic        rx_meta;
  logic        rx_s;

  always_ff @(posedge clk) begin
    if (i_reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= i_rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk) begin
    if (i_reset) begin
      state         <= IDLE;
      cnt           <= 16'd0;
      bit_idx       <= 4'd0;
      shift         <= 8'd0;
      o_data        <= 8'd0;
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      o_busy        <= 1'b0;
    end else begin
      o_valid       <= 1'b0;
      o_frame_error <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= 16'd0;
          if (!rx_s) begin
            state  <= START;
            o_busy <= 1'b1;
          end
        end
        START: begin
          if (cnt == HALF_LAST) begin
            cnt <= 16'd0;
            if (!rx_s) begin
              state   <= DATA;
              bit_idx <= 4'd0;
            end else begin
              state  <= IDLE;
              o_busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt                 <= 16'd0;
            shift[bit_idx[2:0]] <= rx_s;
            bit_idx             <= bit_idx + 4'd1;
            if (bit_idx == 4'd7) state <= STOP;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= 16'd0;
            // Returning to IDLE mid-stop-bit lets a back-to-back start edge be caught.
            if (rx_s) begin
              o_data  <= shift;
              o_valid <= 1'b1;
              state   <= IDLE;
              o_busy  <= 1'b0;
            end else begin
              o_frame_error <= 1'b1;
              state         <= WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        WAIT_HIGH: begin
          cnt <= 16'd0;
          if (rx_s) begin
            state  <= IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= 16'd0;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
